// File: rtl/uart_rx_mem_pkg.sv
// Shared definitions for the memory-mapped UART receiver: register map,
// register bit positions and receive FSM states.
package uart_rx_mem_pkg;

  // Register word offsets (addr = dmem_addr[7:2])
  localparam logic [5:0] REG_DATA   = 6'd0;
  localparam logic [5:0] REG_STATUS = 6'd1;
  localparam logic [5:0] REG_CTRL   = 6'd2;

  // DATA bits
  localparam int DATA_VALID = 8;

  // STATUS bits (count field starts at STAT_CNT)
  localparam int STAT_NE    = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_OVR   = 2;
  localparam int STAT_FERR  = 3;
  localparam int STAT_CNT   = 8;

  // CTRL bits
  localparam int CTRL_EN    = 0;
  localparam int CTRL_IE    = 1;
  localparam int CTRL_FLUSH = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx_mem_fifo.sv
// Synchronous FIFO: registered storage, first word visible combinationally.
// Flush has priority over push and pop; a push into a full FIFO only lands
// when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [W-1:0]  i_din,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic [W-1:0]  o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          w_pop, w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rptr];

  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (!rst && !i_flush && w_push) r_mem[r_wptr] <= i_din;
  end

endmodule

// File: rtl/uart_rx_mem.sv
// Memory-mapped 8N1 UART receiver: rx synchroniser, oversampling deframer,
// receive FIFO and DATA/STATUS/CTRL registers on the dmem bus.
module uart_rx_mem
  import uart_rx_mem_pkg::*;
#(
  parameter int CLKS_PER_BIT = 625,
  parameter int FIFO_AW      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic [3:0]  writeb,
  input  logic        read,
  input  logic [5:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic            r_rx_s1, r_rx_s2;
  rx_state_e       r_state, w_state_n;
  logic [CW-1:0]   r_cnt, w_cnt_n;
  logic [2:0]      r_idx, w_idx_n;
  logic [7:0]      r_shift, w_shift_n;
  logic            w_push, w_ferr_set;

  logic            r_en, r_ie, r_ovr, r_ferr;
  logic [31:0]     r_rdata;

  logic [7:0]      w_dout;
  logic            w_full, w_empty;
  logic [FIFO_AW:0] w_count;
  logic            w_wr0, w_pop, w_flush, w_ovr_set, w_ovr_clr, w_ferr_clr;
  logic [31:0]     w_status;

  // Two-flop synchroniser on the asynchronous rx pin; idles high
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
    end
  end

  // Receive FSM state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_idx   <= w_idx_n;
      r_shift <= w_shift_n;
    end
  end

  // Receive FSM next state: mid-bit sampling, LSB first; disabling aborts the frame
  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_cnt + 1'b1;
    w_idx_n    = r_idx;
    w_shift_n  = r_shift;
    w_push     = 1'b0;
    w_ferr_set = 1'b0;
    if (!r_en) begin
      w_state_n = ST_IDLE;
      w_cnt_n   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_cnt_n = '0;
          if (!r_rx_s2) w_state_n = ST_START;
        end
        ST_START: if (r_cnt == HALF_M1) begin
          w_cnt_n   = '0;
          w_idx_n   = '0;
          w_state_n = r_rx_s2 ? ST_IDLE : ST_DATA;
        end
        ST_DATA: if (r_cnt == FULL_M1) begin
          w_cnt_n          = '0;
          w_shift_n[r_idx] = r_rx_s2;
          w_idx_n          = r_idx + 1'b1;
          if (r_idx == 3'd7) w_state_n = ST_STOP;
        end
        ST_STOP: if (r_cnt == FULL_M1) begin
          w_cnt_n    = '0;
          w_state_n  = ST_IDLE;
          w_push     = r_rx_s2;
          w_ferr_set = ~r_rx_s2;
        end
        default: w_state_n = ST_IDLE;
      endcase
    end
  end

  sync_fifo #(.W(8), .AW(FIFO_AW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (w_shift_n),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Bus decode; a byte is lost to overrun only if nothing frees a slot and no flush
  assign w_wr0      = writeb[0];
  assign w_pop      = read & (addr == REG_DATA);
  assign w_flush    = w_wr0 & (addr == REG_CTRL) & wdata[CTRL_FLUSH];
  assign w_ovr_set  = w_push & w_full & ~(w_pop & ~w_empty) & ~w_flush;
  assign w_ovr_clr  = w_wr0 & (addr == REG_STATUS) & wdata[STAT_OVR];
  assign w_ferr_clr = w_wr0 & (addr == REG_STATUS) & wdata[STAT_FERR];

  // STATUS read word
  always_comb begin
    w_status = '0;
    w_status[STAT_NE]   = ~w_empty;
    w_status[STAT_FULL] = w_full;
    w_status[STAT_OVR]  = r_ovr;
    w_status[STAT_FERR] = r_ferr;
    w_status[STAT_CNT +: FIFO_AW+1] = w_count;
  end

  // CTRL and sticky flags; a set in the same cycle as W1C wins
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en   <= 1'b0;
      r_ie   <= 1'b0;
      r_ovr  <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      if (w_wr0 && addr == REG_CTRL) begin
        r_en <= wdata[CTRL_EN];
        r_ie <= wdata[CTRL_IE];
      end
      r_ovr  <= w_ovr_set  | (r_ovr  & ~w_ovr_clr);
      r_ferr <= w_ferr_set | (r_ferr & ~w_ferr_clr);
    end
  end

  // Registered read data, held between reads
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (read) begin
      case (addr)
        REG_DATA:   r_rdata <= w_empty ? 32'd0 : {23'd0, 1'b1, w_dout};
        REG_STATUS: r_rdata <= w_status;
        REG_CTRL:   r_rdata <= {30'd0, r_ie, r_en};
        default:    r_rdata <= '0;
      endcase
    end
  end

  assign rdata = r_rdata;
  assign irq   = r_ie & ~w_empty;

endmodule
